dct_coeff_zigzag_reader: RTL and testbench

Drains one 8x8 block of 16-bit signed DCT coefficients from the DCT result EBR once `loeffler_dct_88` signals completion. Reads in JPEG zigzag order, quantizes each coefficient by reciprocal multiplication, and streams the results over a valid/ready interface to the entropy coder. Sits between the DCT output memory (read port) and the run-length/Huffman stage.

---
 rtl/dct_coeff_zigzag_reader_pkg.sv | 57 +++++
 rtl/dct_coeff_zigzag_reader_if.sv | 40 ++++
 rtl/dct_coeff_zigzag_reader_quant_reciprocal_rom.sv | 22 ++
 rtl/dct_coeff_zigzag_reader.sv | 206 ++++++++++++++++++++
 tb/tb_dct_coeff_zigzag_reader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_coeff_zigzag_reader_pkg.sv
// Shared JPEG tables for the coefficient reader.
//   ZIGZAG[k]   : raster address (row*8+col) of zigzag position k
//   LUMA_Q[r]   : JPEG luma quality-50 quantizer, raster order
//   CHROMA_Q[r] : JPEG chroma quality-50 quantizer, raster order
//   recip_of(q) : round(65536/q) as a 17-bit unsigned reciprocal
//   state_t     : reader FSM state encoding
package jfpjc_tables;

  localparam int BLOCK_SIZE = 64;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int ZIGZAG [BLOCK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam int LUMA_Q [BLOCK_SIZE] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  localparam int CHROMA_Q [BLOCK_SIZE] = '{
    17,  18,  24,  47,  99,  99,  99,  99,
    18,  21,  26,  66,  99,  99,  99,  99,
    24,  26,  56,  99,  99,  99,  99,  99,
    47,  66,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99
  };

  // Only ever called with constant arguments, so it folds to a table entry.
  // Q=1 yields 65536, which is why the result needs 17 bits.
  function automatic logic [16:0] recip_of(input int q);
    return 17'((65536 + q / 2) / q);
  endfunction

endpackage

// File: rtl/dct_coeff_zigzag_reader_if.sv
// Bundle between the coefficient reader, the DCT result EBR and the entropy
// coder.
//   start             : begin draining a block (DCT finished)
//   result_read_addr  : raster read address into the DCT result EBR
//   result_data_in    : signed EBR read data, one cycle after the address
//   coef_out/index/last/valid, coef_ready : quantized coefficient stream
//   busy, done        : block status
//
// Handshake: a coefficient transfers on a rising clock edge where coef_valid
// and coef_ready are both high. Once coef_valid is high, coef_out, coef_index
// and coef_last hold their values until that transfer; coef_valid never
// depends on coef_ready.
interface dct_coeff_zigzag_reader_if #(
  parameter int OUT_WIDTH = 12
);

  logic                 start;
  logic [5:0]           result_read_addr;
  logic [15:0]          result_data_in;
  logic [OUT_WIDTH-1:0] coef_out;
  logic [5:0]           coef_index;
  logic                 coef_last;
  logic                 coef_valid;
  logic                 coef_ready;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, result_data_in, coef_ready,
    output result_read_addr, coef_out, coef_index, coef_last, coef_valid,
           busy, done
  );

  modport slave (
    output start, result_data_in, coef_ready,
    input  result_read_addr, coef_out, coef_index, coef_last, coef_valid,
           busy, done
  );

endinterface

// File: rtl/dct_coeff_zigzag_reader_quant_reciprocal_rom.sv
// Combinational reciprocal ROM: raster address in, round(65536/Q) out.
//   CHROMA      : 0 = luma quality-50 table, 1 = chroma quality-50 table
//   raster_addr : raster position (row*8+col) of the coefficient
//   recip       : 17-bit unsigned reciprocal of the quantizer step
module quant_reciprocal_rom
  import jfpjc_tables::*;
#(
  parameter int CHROMA = 0
) (
  input  logic [5:0]  raster_addr,
  output logic [16:0] recip
);

  logic [16:0] rom [BLOCK_SIZE];

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_rom
    assign rom[g] = recip_of((CHROMA != 0) ? CHROMA_Q[g] : LUMA_Q[g]);
  end

  assign recip = rom[raster_addr];

endmodule

// File: rtl/dct_coeff_zigzag_reader.sv
// Drains one 8x8 block of signed 16-bit DCT coefficients in zigzag order,
// quantizes each by reciprocal multiplication and streams it out.
//   clock, nreset : single clock, asynchronous active-low reset
//   bus           : EBR read port, start/busy/done, coefficient stream
//   dbg_state     : current FSM state
// Pipeline: address register -> EBR data -> quantize into a 4-entry
// show-ahead FIFO. A read is issued only while FIFO occupancy plus reads
// still in the first two stages is below 4, so every issued read has a
// reserved FIFO slot.
module dct_coeff_zigzag_reader
  import jfpjc_tables::*;
#(
  parameter int OUT_WIDTH = 12,
  parameter int CHROMA    = 0
) (
  input  logic                        clock,
  input  logic                        nreset,
  dct_coeff_zigzag_reader_if.master   bus,
  output state_t                      dbg_state
);

  typedef struct packed {
    logic [OUT_WIDTH-1:0] coef;
    logic [5:0]           idx;
    logic                 last;
  } entry_t;

  localparam logic signed [33:0] ROUND_BIAS = 34'sd32768;
  localparam logic signed [33:0] Q_MAX = (34'sd1 <<< (OUT_WIDTH - 1)) - 34'sd1;
  localparam logic signed [33:0] Q_MIN = -(34'sd1 <<< (OUT_WIDTH - 1));
  localparam logic [OUT_WIDTH-1:0] Q_MAX_N = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] Q_MIN_N = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t     state_q, state_d;
  logic [5:0] zz_q, zz_d;
  logic [5:0] addr_q, addr_d;
  logic       s1_valid_q, s1_valid_d;
  logic [5:0] s1_idx_q, s1_idx_d;
  logic       s2_valid_q, s2_valid_d;
  logic [5:0] s2_idx_q, s2_idx_d;
  logic [5:0] s2_raster_q, s2_raster_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  entry_t     mem_q [FIFO_DEPTH];
  entry_t     mem_d [FIFO_DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  logic                 credit_ok;
  logic                 issue;
  logic                 pop;
  logic [5:0]           rd_zz;
  logic [2:0]           occupancy;
  entry_t               head;
  logic [16:0]          recip;
  logic signed [33:0]   prod;
  logic signed [33:0]   rounded;
  logic signed [33:0]   q_wide;
  logic [OUT_WIDTH-1:0] q_sat;

  // The reciprocal follows the raster address that travelled with the read,
  // so it lines up with the EBR data currently on result_data_in.
  quant_reciprocal_rom #(.CHROMA(CHROMA)) u_recip_rom (
    .raster_addr (s2_raster_q),
    .recip       (recip)
  );

  // Quantize: floor((data*recip + 32768) / 65536) rounds half toward +inf,
  // then saturate to the signed output range.
  always_comb begin
    prod    = 34'($signed(bus.result_data_in)) * 34'($signed({1'b0, recip}));
    rounded = prod + ROUND_BIAS;
    q_wide  = rounded >>> 16;
    if (q_wide > Q_MAX) begin
      q_sat = Q_MAX_N;
    end else if (q_wide < Q_MIN) begin
      q_sat = Q_MIN_N;
    end else begin
      q_sat = q_wide[OUT_WIDTH-1:0];
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign pop       = (count_q != 3'd0) && bus.coef_ready;
  assign occupancy = count_q + {2'b00, s1_valid_q} + {2'b00, s2_valid_q};
  assign credit_ok = occupancy < 3'(FIFO_DEPTH);

  // FSM next state and read issue. The start cycle itself issues zigzag 0 so
  // address 0 is on the EBR port right after start is sampled.
  always_comb begin
    state_d    = state_q;
    zz_d       = zz_q;
    addr_d     = addr_q;
    s1_valid_d = 1'b0;
    s1_idx_d   = s1_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_zz      = zz_q;
    issue      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_STREAM;
          busy_d  = 1'b1;
          rd_zz   = 6'd0;
          zz_d    = 6'd0;
          issue   = credit_ok;
        end
      end
      ST_STREAM: begin
        issue = credit_ok;
      end
      ST_DRAIN: begin
        if (pop && head.last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue) begin
      addr_d     = 6'(ZIGZAG[rd_zz]);
      s1_valid_d = 1'b1;
      s1_idx_d   = rd_zz;
      zz_d       = rd_zz + 6'd1;
      if ((state_q == ST_STREAM) && (rd_zz == 6'd63)) begin
        state_d = ST_DRAIN;
      end
    end
  end

  // Second stage: tags that line up with the EBR data now on the bus.
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_idx_d    = s1_idx_q;
    s2_raster_d = addr_q;
  end

  // Output FIFO: written from the quantizer, read show-ahead.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (s2_valid_q) begin
      mem_d[wr_ptr_q] = '{coef: q_sat, idx: s2_idx_q, last: (s2_idx_q == 6'd63)};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, s2_valid_q} - {2'b00, pop};
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      zz_q        <= 6'd0;
      addr_q      <= 6'd0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= 6'd0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= 6'd0;
      s2_raster_q <= 6'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      zz_q        <= zz_d;
      addr_q      <= addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s2_valid_q  <= s2_valid_d;
      s2_idx_q    <= s2_idx_d;
      s2_raster_q <= s2_raster_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  // Outputs read zero whenever the FIFO is empty.
  assign bus.coef_valid       = (count_q != 3'd0);
  assign bus.coef_out         = bus.coef_valid ? head.coef : '0;
  assign bus.coef_index       = bus.coef_valid ? head.idx : 6'd0;
  assign bus.coef_last        = bus.coef_valid & head.last;
  assign bus.result_read_addr = addr_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_dct_coeff_zigzag_reader.sv
module tb_dct_coeff_zigzag_reader;

  localparam int OW = 12;
  localparam int W  = OW + 6 + 1;
  localparam int OMAX = (1 << (OW - 1)) - 1;
  localparam int OMIN = -(1 << (OW - 1));

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  dct_coeff_zigzag_reader_if #(.OUT_WIDTH(OW)) bus ();
  jfpjc_tables::state_t dbg_state;

  dct_coeff_zigzag_reader #(.OUT_WIDTH(OW), .CHROMA(0)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // EBR model: registered read, data one cycle after the address.
  logic signed [15:0] ebr [64];
  always @(posedge clock) bus.result_data_in <= ebr[bus.result_read_addr];

  // ---------------- reference model ----------------
  int luma_q [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };
  int zz_map [64];
  int inv_zz [64];

  // Zigzag walks the anti-diagonals row+col = s, alternating direction.
  task automatic build_zigzag();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_map[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_map[k] = r * 8 + (s - r); k++; end
      end
    end
    for (int i = 0; i < 64; i++) inv_zz[zz_map[i]] = i;
  endtask

  function automatic int ref_quant(int raster, int data);
    longint recip;
    longint acc;
    longint q;
    recip = (65536 + luma_q[raster] / 2) / luma_q[raster];
    acc   = longint'(data) * recip + 32768;
    q     = acc >>> 16;
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
    return int'(q);
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int addr_log [$];
  logic signed [OW-1:0] got [64];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int blk_hs = 0;
  int first_hs_cyc = 0;
  int last_hs_cyc = 0;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_last_hs = 1'b0;
  logic [W-1:0] prev_word = '0;

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_le(input string name, input longint act, input longint limit);
    n_cmp++;
    if (act > limit) begin
      n_fail++;
      $display("FAIL %s: got %0d expected <= %0d (t=%0t)", name, act, limit, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [W-1:0] word;
    logic [W-1:0] exp_w;
    cyc_cnt++;
    if (!mon_en) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      word = {bus.coef_out, bus.coef_index, bus.coef_last};
      check("done_pulse", longint'(bus.done), longint'(prev_last_hs));
      if (prev_last_hs) check("busy_after_last", longint'(bus.busy), 0);
      if (prev_stall) begin
        check("stall_valid", longint'(bus.coef_valid), 1);
        check("stall_hold", longint'(word), longint'(prev_word));
      end
      if (bus.busy && (addr_log.size() == 0 || addr_log[$] != int'(bus.result_read_addr)))
        addr_log.push_back(int'(bus.result_read_addr));
      check_le("outstanding", longint'(addr_log.size() - blk_hs), 4);
      prev_last_hs = 1'b0;
      if (bus.coef_valid && bus.coef_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_coef", longint'(word), -1);
        end else begin
          exp_w = exp_q.pop_front();
          check("coef_word", longint'(word), longint'(exp_w));
        end
        got[bus.coef_index] = bus.coef_out;
        if (blk_hs == 0) first_hs_cyc = cyc_cnt;
        if (bus.coef_last) begin
          last_hs_cyc  = cyc_cnt;
          prev_last_hs = 1'b1;
        end
        blk_hs++;
      end
      prev_stall = bus.coef_valid && !bus.coef_ready;
      prev_word  = word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_ebr(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: ebr[i] = 16'($urandom);
        default: begin
          case ($urandom_range(0, 3))
            0: ebr[i] = 16'sh7FFF;
            1: ebr[i] = 16'sh8000;
            default: ebr[i] = 16'(int'($urandom_range(0, 600)) - 300);
          endcase
        end
      endcase
    end
  endtask

  task automatic load_expected();
    logic [OW-1:0] c;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      c = OW'(ref_quant(zz_map[k], int'(ebr[zz_map[k]])));
      exp_q.push_back({c, 6'(k), (k == 63)});
    end
    addr_log.delete();
    blk_hs = 0;
  endtask

  task automatic check_block(input int mode);
    int bad;
    bad = 0;
    check("exp_q_empty", exp_q.size(), 0);
    check("addr_count", addr_log.size(), 64);
    for (int k = 0; k < 64; k++) begin
      if (k >= addr_log.size()) bad++;
      else if (addr_log[k] != zz_map[k]) bad++;
    end
    check("addr_order", bad, 0);
    if (mode == 0) check("hs_span", last_hs_cyc - first_hs_cyc, 63);
  endtask

  function automatic logic ready_for(int mode, int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs n_blocks back to back; each further start is raised on the done
  // cycle. A nonzero stray_at pulses start mid-stream.
  task automatic run_blocks(input int mode, input int n_blocks, input int stray_at);
    int cyc;
    int blocks_done;
    load_expected();
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.coef_ready = ready_for(mode, 0);
    cyc = 0;
    blocks_done = 0;
    while (blocks_done < n_blocks && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        blocks_done++;
        check_block(mode);
        if (blocks_done < n_blocks) begin
          randomize_ebr(1);
          load_expected();
          bus.start = 1'b1;
        end
      end
      if (stray_at > 0 && cyc == stray_at) bus.start = 1'b1;
      bus.coef_ready = ready_for(mode, cyc);
    end
    check("blocks_completed", blocks_done, n_blocks);
    bus.coef_ready = 1'b0;
  endtask

  typedef struct {
    string name;
    int    raster;
    int    data;
    int    expv;
  } qvec_t;

  // ---------------- test sequence ----------------
  initial begin
    qvec_t vecs [8];
    int cyc;
    vecs[0] = '{"q_r0_0x0200", 0, 32'h0200, 32};
    vecs[1] = '{"q_r0_m100", 0, -100, -6};
    vecs[2] = '{"q_r0_sat_pos", 0, 32'h7FFF, 2047};
    vecs[3] = '{"q_r0_sat_neg", 0, -32768, -2048};
    vecs[4] = '{"q_r63_49", 63, 49, 0};
    vecs[5] = '{"q_r63_50", 63, 50, 1};
    vecs[6] = '{"q_r0_half_pos", 0, 8, 1};
    vecs[7] = '{"q_r0_half_neg", 0, -8, 0};

    build_zigzag();
    bus.start = 1'b0;
    bus.coef_ready = 1'b0;
    for (int i = 0; i < 64; i++) ebr[i] = '0;

    nreset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_addr", bus.result_read_addr, 0);
    check("rst_coef", bus.coef_out, 0);
    check("rst_index", bus.coef_index, 0);
    check("rst_last", bus.coef_last, 0);
    check("rst_valid", bus.coef_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", dbg_state, jfpjc_tables::ST_IDLE);
    nreset = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      randomize_ebr(1);
      ebr[vecs[v].raster] = 16'(vecs[v].data);
      run_blocks(0, 1, 0);
      check(vecs[v].name, longint'(got[inv_zz[vecs[v].raster]]), vecs[v].expv);
    end

    randomize_ebr(0);
    run_blocks(1, 1, 0);
    randomize_ebr(1);
    run_blocks(2, 1, 0);
    randomize_ebr(0);
    run_blocks(0, 2, 10);

    // Reset at handshake 20.
    randomize_ebr(0);
    load_expected();
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.coef_ready = 1'b1;
    cyc = 0;
    while (blk_hs < 20 && cyc < 500) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      cyc++;
    end
    check("hs20_reached", blk_hs, 20);
    mon_en = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_addr", bus.result_read_addr, 0);
    check("mid_rst_coef", bus.coef_out, 0);
    check("mid_rst_index", bus.coef_index, 0);
    check("mid_rst_last", bus.coef_last, 0);
    check("mid_rst_valid", bus.coef_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    exp_q.delete();
    bus.coef_ready = 1'b0;
    @(posedge clock); #1;
    nreset = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;
    randomize_ebr(1);
    run_blocks(0, 1, 0);

    mon_en = 1'b0;
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
